note_match_ctrl: RTL and testbench

Sequencer that shares the single-bit equality comparator across a WIDTH-bit finger-key pattern. It compares one bit per cycle, from LSB to MSB, against the expected note pattern and accumulates a whole-pattern match. On each completed comparison it updates hit/miss score counters. It sits between the key-input sampler / note generator and the score display logic, and owns the comparator's A/B inputs.

---
 rtl/note_match_ctrl_pkg.sv | 26 ++
 rtl/note_match_ctrl_sat_counter.sv | 39 +++
 rtl/note_match_ctrl.sv | 136 +++++++++++++
 tb/tb_note_match_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_match_ctrl_pkg.sv
// Shared definitions for the note match sequencer.
// Holds the state encoding and the default widths so the score display
// logic sizes its counters the same way the sequencer does.
package note_match_ctrl_pkg;

  // Default key bits per note (one per finger) and the score counter width.
  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_SCORE_W = 8;

  // State encoding constants.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StCmp  = ST_CMP,
    StDone = ST_DONE
  } state_e;

  // Bit index register width: clog2(width), never less than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/note_match_ctrl_sat_counter.sv
// Saturating up-counter used for the hit and miss scores.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the count
//   clr   - synchronous clear, wins over inc
//   inc   - count up by one unless already at the maximum
//   count - current count value
module sat_counter #(
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  logic [SCORE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {SCORE_W{1'b1}})) begin
      count_d = count_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/note_match_ctrl.sv
// Note match sequencer. Walks a captured key pattern against a captured
// expected note pattern one bit per cycle (LSB first) through an external
// single-bit equality comparator, then scores the note as a hit or a miss.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   start                - compare request, only honoured in IDLE
//   pattern, expected    - operands, captured when start is accepted
//   clear_score          - zero both score counters
//   cmp_a, cmp_b         - comparator operands (registered pattern/expected bits)
//   cmp_equal            - comparator result, combinational from cmp_a/cmp_b
//   busy, done, match    - status; done pulses for one cycle with match valid
//   hit_count/miss_count - saturating score counters
module note_match_ctrl
  import note_match_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned SCORE_W = DEFAULT_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   pattern,
  input  logic [WIDTH-1:0]   expected,
  input  logic               clear_score,
  output logic               cmp_a,
  output logic               cmp_b,
  input  logic               cmp_equal,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count
);

  localparam int unsigned     IdxW    = idx_width(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic            acc_q, acc_d;
  logic            match_q, match_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    match_d = match_q;
    cmp_a   = 1'b0;
    cmp_b   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d   = pattern;
          exp_d   = expected;
          idx_d   = '0;
          acc_d   = 1'b1;
          state_d = StCmp;
        end
      end
      StCmp: begin
        busy  = 1'b1;
        cmp_a = pat_q[idx_q];
        cmp_b = exp_q[idx_q];
        acc_d = acc_q & cmp_equal;
        if (idx_q == LastIdx) begin
          // Fold in the last bit directly so match is final on entry to DONE.
          match_d = acc_q & cmp_equal;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      acc_q   <= 1'b1;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

  // Scores move on the DONE->IDLE edge; reset inside the counters wins.
  logic hit_inc, miss_inc;
  assign hit_inc  = (state_q == StDone) &&  match_q;
  assign miss_inc = (state_q == StDone) && !match_q;

  sat_counter #(
    .SCORE_W(SCORE_W)
  ) u_hit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear_score),
    .inc  (hit_inc),
    .count(hit_count)
  );

  sat_counter #(
    .SCORE_W(SCORE_W)
  ) u_miss_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear_score),
    .inc  (miss_inc),
    .count(miss_count)
  );

endmodule

// File: tb/tb_note_match_ctrl.sv
// Directed bench for note_match_ctrl with a behavioural comparator.
module tb_note_match_ctrl;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned SCORE_W = 2;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   pattern;
  logic [WIDTH-1:0]   expected;
  logic               clear_score;
  logic               cmp_a;
  logic               cmp_b;
  logic               cmp_equal;
  logic               busy;
  logic               done;
  logic               match;
  logic [SCORE_W-1:0] hit_count;
  logic [SCORE_W-1:0] miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  note_match_ctrl #(
    .WIDTH  (WIDTH),
    .SCORE_W(SCORE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .expected   (expected),
    .clear_score(clear_score),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_equal  (cmp_equal),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  assign cmp_equal = (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one note from IDLE to the IDLE cycle after DONE; no checking here.
  task automatic run_note(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] e,
                          output int done_seen, output logic m);
    done_seen = 0;
    m = 1'b0;
    pattern = p;
    expected = e;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      if (done) begin
        done_seen++;
        m = match;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, match, cmp_a, cmp_b} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, match, cmp_a, cmp_b});
    else n_pass++;
    n_checks++;
    if ({hit_count, miss_count} !== '0)
      $display("FAIL reset_counts: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_basic_match();
    logic [WIDTH-1:0] p;
    p = 4'b1010;
    pattern = p;
    expected = p;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      n_checks++;
      if ({cmp_a, cmp_b, busy, done} !== {p[i], p[i], 1'b1, 1'b0})
        $display("FAIL basic_walk%0d: got a,b,busy,done=%b expected %b", i,
                 {cmp_a, cmp_b, busy, done}, {p[i], p[i], 1'b1, 1'b0});
      else n_pass++;
      step();
    end
    n_checks++;
    if ({done, busy, match, cmp_a, cmp_b} !== 5'b11100)
      $display("FAIL basic_done: got done,busy,match,a,b=%b expected 11100",
               {done, busy, match, cmp_a, cmp_b});
    else n_pass++;
    step();
    n_checks++;
    if ({done, busy, match, hit_count, miss_count} !== {3'b001, 2'd1, 2'd0})
      $display("FAIL basic_after: got done=%b busy=%b match=%b hit=%0d miss=%0d expected 0 0 1 1 0",
               done, busy, match, hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_msb_miss();
    int busy_cycles;
    int dones;
    logic m;
    busy_cycles = 0;
    dones = 0;
    m = 1'b1;
    pattern = 4'b0011;
    expected = 4'b1011;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        m = match;
        n_checks++;
        if (i !== WIDTH)
          $display("FAIL miss_done_cycle: got cycle %0d expected %0d", i + 1, WIDTH + 1);
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (busy_cycles !== 5)
      $display("FAIL miss_busy_len: got %0d expected 5", busy_cycles);
    else n_pass++;
    n_checks++;
    if ({dones, m} !== {32'd1, 1'b0})
      $display("FAIL miss_result: got dones=%0d match=%b expected 1 0", dones, m);
    else n_pass++;
    n_checks++;
    if ({hit_count, miss_count} !== {2'd1, 2'd1})
      $display("FAIL miss_counts: got hit=%0d miss=%0d expected 1 1", hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_ignore_while_busy();
    int dones;
    dones = 0;
    pattern = 4'b1111;
    expected = 4'b1111;
    start = 1'b1;
    step();                       // cycle 1, idx 0
    start = 1'b0;
    step();                       // cycle 2, idx 1
    pattern = 4'b0000;
    expected = 4'b0101;
    start = 1'b1;
    step();                       // cycle 3, idx 2
    start = 1'b0;
    n_checks++;
    if ({cmp_a, cmp_b} !== 2'b11)
      $display("FAIL busy_captured_ops: got %b expected 11", {cmp_a, cmp_b});
    else n_pass++;
    step();                       // cycle 4, idx 3
    step();                       // cycle 5, DONE
    if (done) dones++;
    n_checks++;
    if (match !== 1'b1)
      $display("FAIL busy_match: got %b expected 1", match);
    else n_pass++;
    start = 1'b1;
    step();                       // cycle 6, IDLE
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      step();
    end
    n_checks++;
    if ({dones, busy} !== {32'd1, 1'b0})
      $display("FAIL busy_one_done: got dones=%0d busy=%b expected 1 0", dones, busy);
    else n_pass++;
    n_checks++;
    if ({hit_count, miss_count} !== {2'd2, 2'd1})
      $display("FAIL busy_counts: got hit=%0d miss=%0d expected 2 1", hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    clear_score = 1'b1;
    step();
    clear_score = 1'b0;
    n_checks++;
    if ({hit_count, miss_count, match} !== {2'd0, 2'd0, 1'b1})
      $display("FAIL clear_idle: got hit=%0d miss=%0d match=%b expected 0 0 1",
               hit_count, miss_count, match);
    else n_pass++;
    pattern = 4'b0101;
    expected = 4'b0101;
    start = 1'b1;
    step();                       // idx 0
    start = 1'b0;
    step();                       // idx 1
    step();                       // idx 2
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, match, cmp_a, cmp_b} !== 5'b0)
      $display("FAIL rstmid_flags: got %b expected 00000", {busy, done, match, cmp_a, cmp_b});
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      step();
    end
    n_checks++;
    if ({dones, hit_count, miss_count} !== {32'd0, 2'd0, 2'd0})
      $display("FAIL rstmid_quiet: got dones=%0d hit=%0d miss=%0d expected 0 0 0",
               dones, hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_saturation_clear();
    int d;
    logic m;
    logic [SCORE_W-1:0] exp_hit;
    for (int n = 1; n <= 5; n++) begin
      run_note(4'b0110, 4'b0110, d, m);
      exp_hit = (n > 3) ? 2'd3 : 2'(n);
      n_checks++;
      if ({hit_count, miss_count} !== {exp_hit, 2'd0})
        $display("FAIL sat_note%0d: got hit=%0d miss=%0d expected %0d 0", n,
                 hit_count, miss_count, exp_hit);
      else n_pass++;
    end
    run_note(4'b0110, 4'b0111, d, m);
    n_checks++;
    if ({hit_count, miss_count} !== {2'd3, 2'd1})
      $display("FAIL sat_miss: got hit=%0d miss=%0d expected 3 1", hit_count, miss_count);
    else n_pass++;
    // Another miss; clear lands on the same edge as its increment.
    pattern = 4'b1000;
    expected = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) step();
    n_checks++;
    if ({done, match} !== 2'b10)
      $display("FAIL clr_done: got done=%b match=%b expected 1 0", done, match);
    else n_pass++;
    clear_score = 1'b1;
    step();
    clear_score = 1'b0;
    n_checks++;
    if ({hit_count, miss_count, busy} !== {2'd0, 2'd0, 1'b0})
      $display("FAIL clr_wins: got hit=%0d miss=%0d busy=%b expected 0 0 0",
               hit_count, miss_count, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int notes;
    int last_done;
    logic prev_done;
    notes = 0;
    last_done = 0;
    prev_done = 1'b0;
    pattern = 4'b1100;
    expected = 4'b1100;
    start = 1'b1;
    step();                       // cycle 1
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (prev_done) begin
        n_checks++;
        if ({hit_count, miss_count} !== {2'((notes + 1) / 2), 2'(notes / 2)})
          $display("FAIL b2b_counts%0d: got hit=%0d miss=%0d expected %0d %0d", notes,
                   hit_count, miss_count, (notes + 1) / 2, notes / 2);
        else n_pass++;
      end
      if (done) begin
        notes++;
        n_checks++;
        if (match !== notes[0])
          $display("FAIL b2b_match%0d: got %b expected %b", notes, match, notes[0]);
        else n_pass++;
        if (notes > 1) begin
          n_checks++;
          if (cyc - last_done !== 6)
            $display("FAIL b2b_period%0d: got %0d expected 6", notes, cyc - last_done);
          else n_pass++;
        end
        last_done = cyc;
        expected = notes[0] ? 4'b0100 : 4'b1100;
        if (notes == 4) start = 1'b0;
      end
      prev_done = done;
      step();
    end
    n_checks++;
    if ({notes, last_done} !== {32'd4, 32'd23})
      $display("FAIL b2b_total: got notes=%0d last=%0d expected 4 23", notes, last_done);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pattern = '0;
    expected = '0;
    clear_score = 1'b0;
    test_reset();
    test_basic_match();
    test_msb_miss();
    test_ignore_while_busy();
    test_reset_mid();
    test_saturation_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
